// File: rtl/bist_ctrl_if.sv
// bist_ctrl_if
// Handshake and result bundle between the test-access logic / datapath and
// the BIST sequencer.
//
// Signals:
//   start, abort        test-access requests into the sequencer
//   signature[NBIT]     MISR signature into the sequencer
//   misr_rst, tpg_load  seed strobes to MISR and TPG
//   tpg_en, test_mode   TPG advance and arbiter request-mux select
//   busy, done          sequencer status
//   result_valid, pass  result qualifiers
//   sig_cap[NBIT]       captured signature
//   sig_so, sig_so_valid serial signature dump
//
// Modports: slave = sequencer side, master = test-access / stimulus side.
interface bist_ctrl_if #(
    parameter int NBIT = 8
);
    logic            start;
    logic            abort;
    logic [NBIT-1:0] signature;
    logic            misr_rst;
    logic            tpg_load;
    logic            tpg_en;
    logic            test_mode;
    logic            busy;
    logic            done;
    logic            result_valid;
    logic            pass;
    logic [NBIT-1:0] sig_cap;
    logic            sig_so;
    logic            sig_so_valid;

    modport slave (
        input  start, abort, signature,
        output misr_rst, tpg_load, tpg_en, test_mode, busy, done,
               result_valid, pass, sig_cap, sig_so, sig_so_valid
    );

    modport master (
        output start, abort, signature,
        input  misr_rst, tpg_load, tpg_en, test_mode, busy, done,
               result_valid, pass, sig_cap, sig_so, sig_so_valid
    );
endinterface

// File: rtl/bist_ctrl.sv
// bist_ctrl
// Built-in self-test sequencer for the grant arbiter and its signature MISR.
// Seeds MISR/TPG, runs N_PATTERNS test cycles, drains the pipeline for
// SETTLE_CYC cycles, captures the MISR signature and compares it to GOLDEN.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bist_ctrl_if.slave (start/abort/signature in; strobes, status,
//          result and serial dump out)
//
// Build option: define BIST_SCAN_DUMP_EN to add a DUMP state that shifts the
// captured signature out on sig_so, MSB first. Without it sig_so and
// sig_so_valid are tied low.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start
// INIT    | one cycle: seed MISR and TPG
// RUN     | TPG advancing, arbiter in test mode, N_PATTERNS cycles
// SETTLE  | TPG halted, test mode held while the pipeline drains
// COMPARE | one cycle: capture signature, evaluate pass
// DUMP    | NBIT cycles: serial signature out (BIST_SCAN_DUMP_EN only)
// DONE    | one cycle: done pulse
module bist_ctrl #(
    parameter int              NBIT       = 8,
    parameter int              N_PATTERNS = 200,
    parameter int              CNT_W      = 16,
    parameter int              SETTLE_CYC = 2,
    parameter logic [NBIT-1:0] GOLDEN     = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    bist_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_SETTLE,
        S_COMPARE,
`ifdef BIST_SCAN_DUMP_EN
        S_DUMP,
`endif
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_PAT    = CNT_W'(N_PATTERNS - 1);
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t            state;
    logic [CNT_W-1:0]  pat_cnt;
    logic [3:0]        settle_cnt;
    logic              misr_rst_q;
    logic              tpg_load_q;
    logic              tpg_en_q;
    logic              test_mode_q;
    logic              busy_q;
    logic              done_q;
    logic              result_valid_q;
    logic              pass_q;
    logic [NBIT-1:0]   sig_cap_q;
    logic              in_busy;

`ifdef BIST_SCAN_DUMP_EN
    localparam int DW = (NBIT > 1) ? $clog2(NBIT) : 1;
    logic [DW-1:0]     dump_idx;
    logic              sig_so_q;
    logic              sig_so_valid_q;
`endif

    // DONE is not a busy state: abort there only clears the result.
    assign in_busy = (state != S_IDLE) && (state != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pat_cnt        <= '0;
            settle_cnt     <= '0;
            misr_rst_q     <= 1'b0;
            tpg_load_q     <= 1'b0;
            tpg_en_q       <= 1'b0;
            test_mode_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            pass_q         <= 1'b0;
            sig_cap_q      <= '0;
`ifdef BIST_SCAN_DUMP_EN
            dump_idx       <= '0;
            sig_so_q       <= 1'b0;
            sig_so_valid_q <= 1'b0;
`endif
        end else if (bus.abort && in_busy) begin
            // Abort wins over every internal transition; capture is skipped.
            state          <= S_IDLE;
            misr_rst_q     <= 1'b0;
            tpg_load_q     <= 1'b0;
            tpg_en_q       <= 1'b0;
            test_mode_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            pass_q         <= 1'b0;
`ifdef BIST_SCAN_DUMP_EN
            sig_so_q       <= 1'b0;
            sig_so_valid_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // A simultaneous abort suppresses the start.
                    if (bus.start && !bus.abort) begin
                        state          <= S_INIT;
                        misr_rst_q     <= 1'b1;
                        tpg_load_q     <= 1'b1;
                        busy_q         <= 1'b1;
                        result_valid_q <= 1'b0;
                        pass_q         <= 1'b0;
                    end
                end
                S_INIT: begin
                    state       <= S_RUN;
                    misr_rst_q  <= 1'b0;
                    tpg_load_q  <= 1'b0;
                    tpg_en_q    <= 1'b1;
                    test_mode_q <= 1'b1;
                    pat_cnt     <= '0;
                end
                S_RUN: begin
                    pat_cnt <= pat_cnt + 1'b1;
                    if (pat_cnt == LAST_PAT) begin
                        state      <= S_SETTLE;
                        tpg_en_q   <= 1'b0;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state       <= S_COMPARE;
                        test_mode_q <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                S_COMPARE: begin
                    sig_cap_q      <= bus.signature;
                    pass_q         <= (bus.signature == GOLDEN);
                    result_valid_q <= 1'b1;
`ifdef BIST_SCAN_DUMP_EN
                    state          <= S_DUMP;
                    dump_idx       <= DW'(NBIT - 1);
                    sig_so_q       <= bus.signature[NBIT-1];
                    sig_so_valid_q <= 1'b1;
`else
                    state          <= S_DONE;
                    busy_q         <= 1'b0;
                    done_q         <= 1'b1;
`endif
                end
`ifdef BIST_SCAN_DUMP_EN
                S_DUMP: begin
                    if (dump_idx == '0) begin
                        state          <= S_DONE;
                        busy_q         <= 1'b0;
                        done_q         <= 1'b1;
                        sig_so_q       <= 1'b0;
                        sig_so_valid_q <= 1'b0;
                    end else begin
                        dump_idx <= dump_idx - 1'b1;
                        sig_so_q <= sig_cap_q[dump_idx - 1'b1];
                    end
                end
`endif
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    if (bus.abort) begin
                        result_valid_q <= 1'b0;
                        pass_q         <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.misr_rst     = misr_rst_q;
    assign bus.tpg_load     = tpg_load_q;
    assign bus.tpg_en       = tpg_en_q;
    assign bus.test_mode    = test_mode_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.result_valid = result_valid_q;
    assign bus.pass         = pass_q;
    assign bus.sig_cap      = sig_cap_q;
`ifdef BIST_SCAN_DUMP_EN
    assign bus.sig_so       = sig_so_q;
    assign bus.sig_so_valid = sig_so_valid_q;
`else
    assign bus.sig_so       = 1'b0;
    assign bus.sig_so_valid = 1'b0;
`endif
endmodule

// File: tb/tb_bist_ctrl.sv
// tb_bist_ctrl
// Self-checking bench for bist_ctrl. A timeline model (cycles elapsed since
// the start edge) predicts every output each cycle; a scenario table covers
// the planned sequences, followed by a mid-test reset and random stimulus.
module tb_bist_ctrl;
    localparam int         NBIT = 8;
    localparam int         NP   = 4;
    localparam int         CW   = 16;
    localparam int         SC   = 2;
    localparam logic [7:0] GOLD = 8'h3C;
`ifdef BIST_SCAN_DUMP_EN
    localparam int DL = NBIT;
`else
    localparam int DL = 0;
`endif
    localparam int CMP_C = NP + 2 + SC;      // COMPARE cycle
    localparam int END_C = NP + 3 + SC + DL; // done cycle

    logic clk;
    logic rst_n;

    bist_ctrl_if #(.NBIT(NBIT)) bus ();

    bist_ctrl #(
        .NBIT(NBIT), .N_PATTERNS(NP), .CNT_W(CW), .SETTLE_CYC(SC), .GOLDEN(GOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a test is a timeline indexed by cycles since start.
    bit         m_active;
    int         m_k;
    bit         m_rv;
    bit         m_pass;
    logic [7:0] m_cap;

    function automatic void model_reset();
        m_active = 1'b0;
        m_k      = 0;
        m_rv     = 1'b0;
        m_pass   = 1'b0;
        m_cap    = 8'h00;
    endfunction

    function automatic void model_step(input bit st, input bit ab, input logic [7:0] sg);
        if (m_active) begin
            if (m_k < END_C && ab) begin
                m_active = 1'b0;
                m_rv     = 1'b0;
                m_pass   = 1'b0;
            end else if (m_k == END_C) begin
                m_active = 1'b0;
                if (ab) begin
                    m_rv   = 1'b0;
                    m_pass = 1'b0;
                end
            end else begin
                if (m_k == CMP_C) begin
                    m_cap  = sg;
                    m_pass = (sg == GOLD);
                    m_rv   = 1'b1;
                end
                m_k++;
            end
        end else if (st && !ab) begin
            m_active = 1'b1;
            m_k      = 1;
            m_rv     = 1'b0;
            m_pass   = 1'b0;
        end
    endfunction

    function automatic logic [17:0] expected();
        logic ms, te, tm, bz, dn, sv, so;
        ms = m_active && (m_k == 1);
        te = m_active && (m_k >= 2) && (m_k <= NP + 1);
        tm = m_active && (m_k >= 2) && (m_k <= NP + 1 + SC);
        bz = m_active && (m_k < END_C);
        dn = m_active && (m_k == END_C);
        sv = (DL > 0) && m_active && (m_k > CMP_C) && (m_k <= CMP_C + DL);
        so = 1'b0;
        if (sv) so = m_cap[NBIT - 1 - (m_k - CMP_C - 1)];
        return {ms, ms, te, tm, bz, dn, m_rv, m_pass, so, sv, m_cap};
    endfunction

    function automatic logic [17:0] actual();
        return {bus.misr_rst, bus.tpg_load, bus.tpg_en, bus.test_mode, bus.busy,
                bus.done, bus.result_valid, bus.pass, bus.sig_so, bus.sig_so_valid,
                bus.sig_cap};
    endfunction

    task automatic check_outputs(input string name);
        logic [17:0] a, e;
        a = actual();
        e = expected();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cycle %0d outputs got %h expected %h", name, cyc, a, e);
        end
    endtask

    task automatic chk_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input string name);
        bit         st, ab;
        logic [7:0] sg;
        st = bus.start;
        ab = bus.abort;
        sg = bus.signature;
        @(posedge clk);
        model_step(st, ab, sg);
        #1;
        cyc++;
        check_outputs(name);
    endtask

    typedef struct {
        logic [7:0] sig;
        int         abort_at;
        int         restart_at;
        int         exp_done;
        bit         exp_rv;
        bit         exp_pass;
        logic [7:0] exp_cap;
    } scn_t;

    scn_t tbl[6];

    initial begin
        int dc;

        tbl[0] = '{GOLD,        0,     0, END_C, 1'b1, 1'b1, GOLD};
        tbl[1] = '{GOLD ^ 8'h01, 0,    0, END_C, 1'b1, 1'b0, GOLD ^ 8'h01};
        tbl[2] = '{GOLD,        4,     0, 0,     1'b0, 1'b0, GOLD ^ 8'h01};
        tbl[3] = '{GOLD,        0,     3, END_C, 1'b1, 1'b1, GOLD};
        tbl[4] = '{8'hFF,       CMP_C, 0, 0,     1'b0, 1'b0, GOLD};
        tbl[5] = '{8'h5A,       END_C, 0, END_C, 1'b0, 1'b0, 8'h5A};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.signature = GOLD;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick("idle");

        // Scenario table
        for (int r = 0; r < 6; r++) begin
            bus.signature = tbl[r].sig;
            bus.start     = 1'b1;
            tick("scn_start");
            bus.start = 1'b0;
            dc = 0;
            for (int c = 1; c <= END_C + 6; c++) begin
                if (bus.done && dc == 0) dc = c;
                bus.abort = (c == tbl[r].abort_at);
                bus.start = (c == tbl[r].restart_at);
                tick("scn_step");
            end
            bus.abort = 1'b0;
            bus.start = 1'b0;
            chk_val($sformatf("scn%0d_done_cycle", r), dc, tbl[r].exp_done);
            chk_val($sformatf("scn%0d_result_valid", r), int'(bus.result_valid), int'(tbl[r].exp_rv));
            chk_val($sformatf("scn%0d_pass", r), int'(bus.pass), int'(tbl[r].exp_pass));
            chk_val($sformatf("scn%0d_sig_cap", r), int'(bus.sig_cap), int'(tbl[r].exp_cap));
        end

        // Reset in the middle of a test, then a full clean run
        bus.signature = GOLD;
        bus.start     = 1'b1;
        tick("rst_start");
        bus.start = 1'b0;
        repeat (5) tick("rst_run");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rst_mid_async");
        chk_val("rst_mid_busy", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        check_outputs("rst_mid_held");
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b1;
        tick("post_rst_start");
        bus.start = 1'b0;
        dc = 0;
        for (int c = 1; c <= END_C + 3; c++) begin
            if (bus.done && dc == 0) dc = c;
            tick("post_rst_run");
        end
        chk_val("post_rst_done_cycle", dc, END_C);
        chk_val("post_rst_pass", int'(bus.pass), 1);

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.abort = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 2))
                0:       bus.signature = GOLD;
                1:       bus.signature = GOLD ^ 8'h01;
                default: bus.signature = 8'($urandom);
            endcase
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bist_ctrl.md
# bist_ctrl

Built-in self-test sequencer for the grant arbiter and its 8-bit signature MISR. On `start` it seeds the MISR, runs the test-pattern generator for a fixed number of cycles with the arbiter in test mode, and waits for the pipeline to drain. It then compares the MISR signature against a golden value and reports pass/fail. It sits between the test-access logic (start/abort, results) and the TPG/arbiter/MISR datapath.

## Interface
- `NBIT`, 8, signature width (matches MISR).
- `N_PATTERNS`, 200, number of RUN cycles; legal range 1..2^CNT_W-1.
- `CNT_W`, 16, width of the pattern counter.
- `SETTLE_CYC`, 2, drain cycles after the last pattern; legal range 1..15.
- `GOLDEN`, 8'h00, expected signature.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; sampled only in IDLE.
- `abort` in 1: level; returns to IDLE from any busy state.
- `signature` in NBIT: MISR signature.
- `misr_rst` out 1: active-high synchronous seed load to the MISR.
- `tpg_load` out 1: load the TPG seed.
- `tpg_en` out 1: advance the TPG.
- `test_mode` out 1: arbiter request mux selects TPG patterns.
- `busy` out 1: high in INIT, RUN, SETTLE, COMPARE and DUMP.
- `done` out 1: one-cycle pulse at the end of a test.
- `result_valid` out 1: `pass`/`sig_cap` hold a valid result.
- `pass` out 1: `sig_cap == GOLDEN`.
- `sig_cap` out NBIT: captured signature.
- `sig_so` out 1: serial signature (only with `BIST_SCAN_DUMP_EN`).
- `sig_so_valid` out 1: qualifies `sig_so` (only with `BIST_SCAN_DUMP_EN`).

## Operation
- States: IDLE, INIT, RUN, SETTLE, COMPARE, DUMP (macro only), DONE. Encoding is free.
- Reset: state IDLE; every output 0; counters 0; `sig_cap` 0.
- IDLE:
  - `start`=1 → INIT.
  - On that transition, `result_valid` and `pass` clear.
- INIT, 1 cycle: `misr_rst`=1, `tpg_load`=1 → RUN. The pattern counter clears.
- RUN:
  - `tpg_en`=1, `test_mode`=1.
  - The counter increments every cycle.
  - When counter == N_PATTERNS-1 → SETTLE. RUN lasts exactly N_PATTERNS cycles.
- SETTLE: `test_mode`=1, `tpg_en`=0 for SETTLE_CYC cycles → COMPARE.
- COMPARE, 1 cycle:
  - `sig_cap` <= `signature`.
  - `pass` <= (`signature` == GOLDEN).
  - `result_valid` <= 1.
  - → DUMP if the macro is defined, else → DONE.
- DONE, 1 cycle: `done`=1 → IDLE.
- `start` held high after DONE starts a new test: IDLE→INIT on the next edge.
- `abort`=1 in any busy state:
  - Next state IDLE.
  - All strobes drop on the same edge.
  - `result_valid`=0, `pass`=0, no `done` pulse.
  - `abort` has priority over `start` and over all internal transitions.
- `start` while busy is ignored. `abort` in IDLE or DONE has no effect, except that in DONE it forces `result_valid`=0 and `pass`=0.
- `misr_rst`, `tpg_load`, `tpg_en` and `test_mode` are registered Moore outputs; they must be glitch-free.

## Timing
- Edge 0 samples `start`=1. INIT occupies cycle 1 (after edge 0).
- RUN occupies cycles 2..N+1.
- SETTLE occupies cycles N+2..N+1+S.
- COMPARE occupies cycle N+2+S; `result_valid`/`pass` are visible from cycle N+3+S.
- Without the macro: `done` is high in cycle N+3+S, `busy` low from cycle N+3+S.
- With the macro: DUMP spans cycles N+3+S..N+2+S+NBIT, and `done` is high in cycle N+3+S+NBIT.
- Reset asserted mid-test clears everything immediately (asynchronous). There is no resume.

## Configuration
- `BIST_SCAN_DUMP_EN` defined:
  - A DUMP state follows COMPARE and lasts NBIT cycles.
  - `sig_so` = `sig_cap` MSB first, one bit per cycle; `sig_so_valid`=1 throughout DUMP.
  - `busy` stays high during DUMP. `abort` in DUMP behaves as in other busy states.
- Undefined: no DUMP state; `sig_so` and `sig_so_valid` are tied to 0.

## Test plan
- N_PATTERNS=4, SETTLE_CYC=2, no macro, signature stub = GOLDEN: pulse `start` at edge 0.
  - Response: `misr_rst`/`tpg_load` high in cycle 1 only; `tpg_en` high in cycles 2–5; `test_mode` high in cycles 2–7.
  - Then `done` high in cycle 9 only, `pass`=1, `result_valid`=1.
- Same setup with signature stub = GOLDEN^8'h01 → `done` in cycle 9, `pass`=0, `sig_cap`=GOLDEN^8'h01.
- Assert `abort` in cycle 4 (RUN) → IDLE at the next edge; `tpg_en`/`test_mode` low, no `done`, `result_valid`=0.
- Pulse `start` again while `busy` in cycle 3 → no restart; `done` is still in cycle 9.
- Drop `rst_n` in cycle 6 → all outputs 0 immediately. Release `rst_n`, then `start` → a full, correct sequence.
- `BIST_SCAN_DUMP_EN`, signature 8'hA5 → `sig_so` = 1,0,1,0,0,1,0,1 in cycles 9–16 with `sig_so_valid`; `done` in cycle 17.
